// File: rtl/nms_pkg.sv
// -----------------------------------------------------------------------------
// nms_pkg
// Shared definitions for the FAST-corner non-maximum suppression block:
//   TIE_STRICT / TIE_RASTER : tie-break mode selectors
//   win_idx(r, c, win)      : raster index of window element (r, c)
//   centre_idx(win)         : raster index of the window centre
//   win_legal(win)          : legal window sizes (3 and 5)
// -----------------------------------------------------------------------------
package nms_pkg;

  localparam int TIE_STRICT = 0;
  localparam int TIE_RASTER = 1;

  function automatic int win_idx(input int r, input int c, input int win);
    return r * win + c;
  endfunction

  function automatic int centre_idx(input int win);
    return win_idx(win / 2, win / 2, win);
  endfunction

  function automatic bit win_legal(input int win);
    return (win == 3) || (win == 5);
  endfunction

endpackage

// File: rtl/nms_window_p_if.sv
// -----------------------------------------------------------------------------
// nms_window_p_if
// Bundles the window/coordinate input beat and the suppressed corner output
// beat of nms_window_p.
//   master : upstream window generator + downstream FIFO side
//   slave  : the nms_window_p block
// Inputs : valid_in, sof_in, iscorner, thr_in, x/y_coord_in, win_in
// Outputs: valid_out, corner_out, x/y_coord_out, corner_count
// -----------------------------------------------------------------------------
interface nms_window_p_if #(
  parameter int SCORE_W = 13,
  parameter int COORD_W = 10,
  parameter int WIN     = 3,
  parameter int CNT_W   = 16
);

  logic                       valid_in;
  logic                       sof_in;
  logic                       iscorner;
  logic [SCORE_W-1:0]         thr_in;
  logic [COORD_W-1:0]         x_coord_in;
  logic [COORD_W-1:0]         y_coord_in;
  logic [WIN*WIN*SCORE_W-1:0] win_in;

  logic                       valid_out;
  logic                       corner_out;
  logic [COORD_W-1:0]         x_coord_out;
  logic [COORD_W-1:0]         y_coord_out;
  logic [CNT_W-1:0]           corner_count;

  modport master (
    output valid_in, sof_in, iscorner, thr_in, x_coord_in, y_coord_in, win_in,
    input  valid_out, corner_out, x_coord_out, y_coord_out, corner_count
  );

  modport slave (
    input  valid_in, sof_in, iscorner, thr_in, x_coord_in, y_coord_in, win_in,
    output valid_out, corner_out, x_coord_out, y_coord_out, corner_count
  );

endinterface

// File: rtl/nms_corner_counter.sv
// -----------------------------------------------------------------------------
// nms_corner_counter
// Per-frame saturating corner counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   ce_i       : clock enable, counter holds when low
//   sof_i      : current beat starts a frame -> load (inc_i ? 1 : 0)
//   inc_i      : current beat is a corner -> +1, saturating at all-ones
//   count_o    : current count
// -----------------------------------------------------------------------------
module nms_corner_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce_i,
  input  logic             sof_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: count_d is given its hold value first so every path assigns it and
  // no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (sof_i) begin
      count_d = inc_i ? CNT_W'(1) : '0;
    end else if (inc_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count_q <= '0;
    else if (ce_i) count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/nms_window_p.sv
// -----------------------------------------------------------------------------
// nms_window_p
// Two-stage non-maximum suppression for the FAST corner pipeline.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   ce   : clock enable, whole pipeline holds when low
//   bus  : nms_window_p_if slave (window beat in, corner beat + count out)
// Stage 1 registers one "centre dominates neighbour" bit per neighbour plus
// the threshold/iscorner candidate flag; stage 2 AND-reduces them into
// corner_out and feeds the per-frame corner counter.
// -----------------------------------------------------------------------------
module nms_window_p
  import nms_pkg::*;
#(
  parameter int SCORE_W  = 13,
  parameter int COORD_W  = 10,
  parameter int WIN      = 3,
  parameter int TIE_MODE = TIE_STRICT,
  parameter int CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  nms_window_p_if.slave  bus
);

  localparam int NW = WIN * WIN;
  localparam int C  = centre_idx(WIN);

  if (!win_legal(WIN)) begin : g_bad_win
    $error("nms_window_p: WIN must be 3 or 5");
  end
  if ((TIE_MODE != TIE_STRICT) && (TIE_MODE != TIE_RASTER)) begin : g_bad_tie
    $error("nms_window_p: TIE_MODE must be 0 or 1");
  end

  // ---------------------------------------------------------------- stage 1
  logic [SCORE_W-1:0] centre_score;
  logic [NW-1:0]      dom_d, dom_q;
  logic               cand_d, cand_q;
  logic               v1_q, s1_q;
  logic [COORD_W-1:0] x1_q, y1_q;

  assign centre_score = bus.win_in[C*SCORE_W +: SCORE_W];

  // dom_d[idx] = centre beats neighbour idx. In raster mode the centre wins
  // ties against neighbours that come after it in raster order, so only the
  // earliest equal score survives.
  for (genvar idx = 0; idx < NW; idx++) begin : g_cmp
    if (idx == C) begin : g_centre
      assign dom_d[idx] = 1'b1;
    end else begin : g_nb
      logic [SCORE_W-1:0] nb_score;
      assign nb_score = bus.win_in[idx*SCORE_W +: SCORE_W];
      if ((TIE_MODE == TIE_RASTER) && (idx > C)) begin : g_ge
        assign dom_d[idx] = (centre_score >= nb_score);
      end else begin : g_gt
        assign dom_d[idx] = (centre_score > nb_score);
      end
    end
  end

  assign cand_d = bus.valid_in & bus.iscorner & (centre_score >= bus.thr_in);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dom_q  <= '0;
      cand_q <= 1'b0;
      v1_q   <= 1'b0;
      s1_q   <= 1'b0;
      x1_q   <= '0;
      y1_q   <= '0;
    end else if (ce) begin
      dom_q  <= dom_d;
      cand_q <= cand_d;
      v1_q   <= bus.valid_in;
      s1_q   <= bus.sof_in & bus.valid_in;
      x1_q   <= bus.x_coord_in;
      y1_q   <= bus.y_coord_in;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic               corner_d;
  logic               valid_q, corner_q;
  logic [COORD_W-1:0] x2_q, y2_q;

  assign corner_d = v1_q & cand_q & (&dom_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      corner_q <= 1'b0;
      x2_q     <= '0;
      y2_q     <= '0;
    end else if (ce) begin
      valid_q  <= v1_q;
      corner_q <= corner_d;
      x2_q     <= x1_q;
      y2_q     <= y1_q;
    end
  end

  // The counter advances on the same edge that publishes the stage-2 beat, so
  // corner_count already includes the corner shown on corner_out.
  nms_corner_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .ce_i    (ce),
    .sof_i   (s1_q),
    .inc_i   (corner_d),
    .count_o (bus.corner_count)
  );

  assign bus.valid_out   = valid_q;
  assign bus.corner_out  = corner_q;
  assign bus.x_coord_out = x2_q;
  assign bus.y_coord_out = y2_q;

endmodule

// File: tb/tb_nms_window_p.sv
// -----------------------------------------------------------------------------
// tb_nms_window_p
// Three instances: A = WIN 3 strict (CNT_W 3), B = WIN 3 raster tie-break,
// C = WIN 5 strict. Table vectors each carry sof so the expected count is the
// vector's own corner bit; hand sequences cover ce gating, streaming,
// saturation and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_nms_window_p;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce  = 1'b0;

  always #5 clk = ~clk;

  nms_window_p_if #(.SCORE_W(13), .COORD_W(10), .WIN(3), .CNT_W(3))  if_a ();
  nms_window_p_if #(.SCORE_W(13), .COORD_W(10), .WIN(3), .CNT_W(16)) if_b ();
  nms_window_p_if #(.SCORE_W(13), .COORD_W(10), .WIN(5), .CNT_W(16)) if_c ();

  nms_window_p #(.SCORE_W(13), .COORD_W(10), .WIN(3), .TIE_MODE(0), .CNT_W(3)) u_a (
    .clk(clk), .rst(rst), .ce(ce), .bus(if_a));
  nms_window_p #(.SCORE_W(13), .COORD_W(10), .WIN(3), .TIE_MODE(1), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .ce(ce), .bus(if_b));
  nms_window_p #(.SCORE_W(13), .COORD_W(10), .WIN(5), .TIE_MODE(0), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .ce(ce), .bus(if_c));

  typedef struct packed {
    logic [1:0]  sel;
    logic [12:0] base;
    logic [12:0] centre;
    logic        sp_en;
    logic [4:0]  sp_idx;
    logic [12:0] sp_val;
    logic [12:0] thr;
    logic        isc;
    logic        valid;
    logic        exp_corner;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];
  int   n_checks = 0;
  int   n_err    = 0;
  int   m_cnt [3];

  function automatic vec_t mk(input int sel, input int base, input int centre,
                              input int sp_en, input int sp_idx, input int sp_val,
                              input int thr, input int isc, input int valid,
                              input int exp_c);
    vec_t v;
    v.sel        = 2'(sel);
    v.base       = 13'(base);
    v.centre     = 13'(centre);
    v.sp_en      = (sp_en != 0);
    v.sp_idx     = 5'(sp_idx);
    v.sp_val     = 13'(sp_val);
    v.thr        = 13'(thr);
    v.isc        = (isc != 0);
    v.valid      = (valid != 0);
    v.exp_corner = (exp_c != 0);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    if_a.valid_in = 1'b0; if_a.sof_in = 1'b0; if_a.iscorner = 1'b0;
    if_b.valid_in = 1'b0; if_b.sof_in = 1'b0; if_b.iscorner = 1'b0;
    if_c.valid_in = 1'b0; if_c.sof_in = 1'b0; if_c.iscorner = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v, input logic [9:0] x, input logic [9:0] y,
                           input logic sof);
    logic [24:0][12:0] w;
    int c;
    c = (v.sel == 2'd2) ? 12 : 4;
    for (int k = 0; k < 25; k++) w[k] = v.base;
    w[c] = v.centre;
    if (v.sp_en) w[v.sp_idx] = v.sp_val;
    drive_idle();
    case (v.sel)
      2'd0: begin
        if_a.valid_in = v.valid; if_a.sof_in = sof; if_a.iscorner = v.isc;
        if_a.thr_in = v.thr; if_a.x_coord_in = x; if_a.y_coord_in = y;
        if_a.win_in = w[8:0];
      end
      2'd1: begin
        if_b.valid_in = v.valid; if_b.sof_in = sof; if_b.iscorner = v.isc;
        if_b.thr_in = v.thr; if_b.x_coord_in = x; if_b.y_coord_in = y;
        if_b.win_in = w[8:0];
      end
      default: begin
        if_c.valid_in = v.valid; if_c.sof_in = sof; if_c.iscorner = v.isc;
        if_c.thr_in = v.thr; if_c.x_coord_in = x; if_c.y_coord_in = y;
        if_c.win_in = w;
      end
    endcase
  endtask

  task automatic get_out(input int sel, output logic [31:0] v, output logic [31:0] c,
                         output logic [31:0] x, output logic [31:0] y,
                         output logic [31:0] cnt);
    case (sel)
      0: begin
        v = 32'(if_a.valid_out); c = 32'(if_a.corner_out);
        x = 32'(if_a.x_coord_out); y = 32'(if_a.y_coord_out); cnt = 32'(if_a.corner_count);
      end
      1: begin
        v = 32'(if_b.valid_out); c = 32'(if_b.corner_out);
        x = 32'(if_b.x_coord_out); y = 32'(if_b.y_coord_out); cnt = 32'(if_b.corner_count);
      end
      default: begin
        v = 32'(if_c.valid_out); c = 32'(if_c.corner_out);
        x = 32'(if_c.x_coord_out); y = 32'(if_c.y_coord_out); cnt = 32'(if_c.corner_count);
      end
    endcase
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] v, c, x, y, cnt;
    for (int s = 0; s < 3; s++) begin
      get_out(s, v, c, x, y, cnt);
      check($sformatf("%s inst%0d valid_out", tag, s), v, 0);
      check($sformatf("%s inst%0d corner_out", tag, s), c, 0);
      check($sformatf("%s inst%0d x_coord_out", tag, s), x, 0);
      check($sformatf("%s inst%0d y_coord_out", tag, s), y, 0);
      check($sformatf("%s inst%0d corner_count", tag, s), cnt, 0);
    end
  endtask

  // Streams n back-to-back beats into instance A; beat 0 carries sof and is a
  // corner only if first_corner, the rest are corners.
  task automatic stream_a(input int n, input logic first_corner);
    logic        exp_c [16];
    int          exp_n [16];
    int          cm;
    logic [31:0] v, c, x, y, cnt;
    vec_t        bv;
    cm = m_cnt[0];
    for (int b = 0; b < n; b++) begin
      exp_c[b] = (b == 0) ? first_corner : 1'b1;
      if (b == 0)                 cm = exp_c[b] ? 1 : 0;
      else if (exp_c[b] && cm < 7) cm++;
      exp_n[b] = cm;
    end
    for (int j = 0; j <= n + 1; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        get_out(0, v, c, x, y, cnt);
        check($sformatf("stream%0d beat%0d valid_out", n, j - 2), v, 1);
        check($sformatf("stream%0d beat%0d corner_out", n, j - 2), c, 32'(exp_c[j-2]));
        check($sformatf("stream%0d beat%0d x_coord_out", n, j - 2), x, 32'(j - 2 + 10));
        check($sformatf("stream%0d beat%0d corner_count", n, j - 2), cnt, 32'(exp_n[j-2]));
      end
      if (j < n) begin
        bv = mk(0, 99, 100, 0, 0, 0, 0, ((j == 0) ? first_corner : 1'b1), 1, 0);
        drive_vec(bv, 10'(j + 10), 10'(j + 20), (j == 0));
      end else begin
        drive_idle();
      end
    end
    @(negedge clk);
    get_out(0, v, c, x, y, cnt);
    check($sformatf("stream%0d tail valid_out", n), v, 0);
    check($sformatf("stream%0d tail corner_count", n), cnt, 32'(cm));
    m_cnt[0] = cm;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] v, c, x, y, cnt;
    vec_t        bv;

    //        sel base  ctr  spE idx val   thr isc vld exp
    vecs[0]  = mk(0,   99,  100, 0, 0,  0,    0,  1, 1, 1);
    vecs[1]  = mk(0,   99,  100, 1, 3,  100,  0,  1, 1, 0);
    vecs[2]  = mk(0,   99,  100, 1, 8,  100,  0,  1, 1, 0);
    vecs[3]  = mk(1,   10,  50,  1, 8,  50,   0,  1, 1, 1);
    vecs[4]  = mk(1,   10,  50,  1, 0,  50,   0,  1, 1, 0);
    vecs[5]  = mk(1,   10,  50,  1, 5,  50,   0,  1, 1, 1);
    vecs[6]  = mk(1,   10,  50,  1, 3,  50,   0,  1, 1, 0);
    vecs[7]  = mk(2,   0,   4000,1, 24, 4001, 0,  1, 1, 0);
    vecs[8]  = mk(2,   0,   4000,1, 24, 3999, 0,  1, 1, 1);
    vecs[9]  = mk(2,   0,   4000,1, 0,  4000, 0,  1, 1, 0);
    vecs[10] = mk(0,   0,   199, 0, 0,  0,    200,1, 1, 0);
    vecs[11] = mk(0,   0,   200, 0, 0,  0,    200,1, 1, 1);
    vecs[12] = mk(0,   0,   200, 0, 0,  0,    200,0, 1, 0);
    vecs[13] = mk(0,   0,   200, 0, 0,  0,    200,1, 0, 0);
    vecs[14] = mk(0,   4095,4096,0, 0,  0,    0,  1, 1, 1);
    vecs[15] = mk(1,   8191,8191,0, 0,  0,    0,  1, 1, 0);
    vecs[16] = mk(2,   8190,8191,0, 0,  0,    8191,1,1, 1);
    vecs[17] = mk(1,   100, 150, 1, 7,  151,  0,  1, 1, 0);

    for (int s = 0; s < 3; s++) m_cnt[s] = 0;
    if_a.thr_in = '0; if_a.x_coord_in = '0; if_a.y_coord_in = '0; if_a.win_in = '0;
    if_b.thr_in = '0; if_b.x_coord_in = '0; if_b.y_coord_in = '0; if_b.win_in = '0;
    if_c.thr_in = '0; if_c.x_coord_in = '0; if_c.y_coord_in = '0; if_c.win_in = '0;
    drive_idle();

    // Reset state
    rst = 1'b0;
    ce  = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Table vectors: drive, one idle beat, sample two ce edges later
    for (int i = 0; i < NVEC; i++) begin
      int s;
      s = int'(vecs[i].sel);
      drive_vec(vecs[i], 10'(5 + i), 10'(7 + 2 * i), 1'b1);
      @(negedge clk);
      drive_idle();
      @(negedge clk);
      if (vecs[i].valid) m_cnt[s] = vecs[i].exp_corner ? 1 : 0;
      get_out(s, v, c, x, y, cnt);
      check($sformatf("vec%0d valid_out", i), v, 32'(vecs[i].valid));
      check($sformatf("vec%0d corner_out", i), c, 32'(vecs[i].exp_corner));
      if (vecs[i].valid) begin
        check($sformatf("vec%0d x_coord_out", i), x, 32'(5 + i));
        check($sformatf("vec%0d y_coord_out", i), y, 32'(7 + 2 * i));
      end
      check($sformatf("vec%0d corner_count", i), cnt, 32'(m_cnt[s]));
    end

    // Four back-to-back corner beats, sof on a corner -> count 1..4
    stream_a(4, 1'b1);
    // Saturation: sof non-corner then nine corners -> 0,1..7,7,7
    stream_a(10, 1'b0);

    // ce gating: three ce=0 cycles between the two pipeline edges
    @(negedge clk);
    bv = mk(0, 99, 100, 0, 0, 0, 0, 1, 1, 1);
    drive_vec(bv, 10'd33, 10'd44, 1'b1);
    @(negedge clk);
    drive_idle();
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      get_out(0, v, c, x, y, cnt);
      check($sformatf("ce_hold%0d valid_out", k), v, 0);
      check($sformatf("ce_hold%0d corner_out", k), c, 0);
      check($sformatf("ce_hold%0d corner_count", k), cnt, 7);
    end
    ce = 1'b1;
    @(negedge clk);
    get_out(0, v, c, x, y, cnt);
    check("ce_release valid_out", v, 1);
    check("ce_release corner_out", c, 1);
    check("ce_release x_coord_out", x, 33);
    check("ce_release y_coord_out", y, 44);
    check("ce_release corner_count", cnt, 1);
    m_cnt[0] = 1;

    // Asynchronous reset mid-stream
    @(negedge clk);
    bv = mk(0, 99, 100, 0, 0, 0, 0, 1, 1, 1);
    drive_vec(bv, 10'd1, 10'd2, 1'b1);
    @(negedge clk);
    drive_vec(bv, 10'd3, 10'd4, 1'b0);
    @(negedge clk);
    drive_vec(bv, 10'd5, 10'd6, 1'b0);
    get_out(0, v, c, x, y, cnt);
    check("pre_rst valid_out", v, 1);
    check("pre_rst x_coord_out", x, 1);
    check("pre_rst corner_count", cnt, 1);
    #2 rst = 1'b0;
    #1 check_all_zero("async_rst");
    drive_idle();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      get_out(0, v, c, x, y, cnt);
      check("post_rst valid_out", v, 0);
      check("post_rst corner_count", cnt, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/nms_window_p.md
Name: nms_window_p

Overview:
Parametrised non-maximum suppression for the FAST corner pipeline. It sits between the score/line-buffer window generator and the corner output FIFO. It accepts a WIN x WIN score window centred on a candidate pixel. It emits the centre coordinate with a corner flag that is asserted only when the centre is a local maximum, meets a run-time threshold and was flagged as a corner upstream. It adds valid tracking, selectable tie-breaking, and a saturating per-frame corner counter.

Parameters:
SCORE_W, 13, score width in bits (unsigned).
COORD_W, 10, x/y coordinate width.
WIN, 3, window side length; legal values are 3 and 5 only (elaboration error otherwise).
TIE_MODE, 0, 0 = strict (centre must be > all neighbours); 1 = raster tie-break (earliest equal score in raster order wins).
CNT_W, 16, corner counter width.

Ports:
clk  in  1  clock, all logic rising-edge.
rst  in  1  asynchronous active-low reset.
ce  in  1  clock enable; when 0 every register holds.
valid_in  in  1  window/coordinate data valid.
sof_in  in  1  start-of-frame marker, qualified by valid_in.
iscorner  in  1  upstream corner flag for the centre pixel.
thr_in  in  SCORE_W  minimum centre score; held static within a frame.
x_coord_in  in  COORD_W  centre x.
y_coord_in  in  COORD_W  centre y.
win_in  in  WIN*WIN*SCORE_W  flattened window; element (r,c) has idx = r*WIN+c at bits [(idx+1)*SCORE_W-1 : idx*SCORE_W]; centre idx C = (WIN*WIN-1)/2.
valid_out  out  1  output beat valid.
corner_out  out  1  centre is a surviving corner (meaningful only with valid_out).
x_coord_out  out  COORD_W  delayed centre x.
y_coord_out  out  COORD_W  delayed centre y.
corner_count  out  CNT_W  corners emitted in the current frame, saturating.

Behaviour:
- Reset (rst=0, asynchronous): valid_out, corner_out, x/y_coord_out and corner_count go to 0, and all pipeline registers go to 0. Release is synchronous to clk.
- Pipeline depth is 2 ce-qualified cycles. An input sampled at ce-edge N appears at the outputs after ce-edge N+1. Cycles with ce=0 do not advance the pipeline.
- Stage 1, on a ce edge:
  - For each neighbour idx != C, register cmp[idx].
  - TIE_MODE=0: cmp = (centre > win[idx]).
  - TIE_MODE=1: cmp = (centre > win[idx]) for idx < C, and (centre >= win[idx]) for idx > C.
  - Register cand = valid_in & iscorner & (centre >= thr_in).
  - Register v1 = valid_in and s1 = sof_in & valid_in.
  - Register the coordinates.
- Stage 2, on a ce edge:
  - corner_out = cand & AND-reduce of all WIN*WIN-1 cmp bits.
  - valid_out = v1; coordinates are forwarded.
- corner_out is forced to 0 whenever v1 = 0. Coordinates still propagate when invalid and their value is don't-care.
- All comparisons are unsigned, full SCORE_W width, with no truncation.
- corner_count updates on a ce edge, driven by the stage-2 result:
  - If the stage-2 beat carries sof (s1 delayed), the count loads 1 if that beat is a corner, otherwise 0. SOF plus a simultaneous corner therefore gives 1.
  - Otherwise the count increments by 1 on each corner beat.
  - The count saturates at 2^CNT_W-1 and never wraps.
- Back-to-back valid beats are supported at one beat per ce cycle, with no bubbles.
- A reset mid-frame clears the count and drops all in-flight beats. No output is produced for them.

Decomposition:
- Package nms_pkg:
  - TIE_STRICT=0 and TIE_RASTER=1 constants.
  - Function win_idx(r,c,WIN).
  - Function centre_idx(WIN).
  - Legal-WIN check.
- Sub-module nms_corner_counter (CNT_W): saturating counter with sof-load and increment inputs, async active-low reset, ce.
- Comparator array and reduction stay inline, built with a generate loop over idx.

Test Plan:
1. WIN=3, TIE_MODE=0, thr=0: centre 100, all neighbours 99, iscorner=1, valid=1, x=5, y=7 -> two ce cycles later valid_out=1, corner_out=1, x_coord_out=5, y_coord_out=7; with one neighbour set to 100 -> corner_out=0.
2. TIE_MODE=1, WIN=3: centre 50, idx 8 = 50, others 10 -> corner_out=1. Centre 50, idx 0 = 50 -> corner_out=0.
3. WIN=5: centre 4000, idx 24 = 4001, others 0 -> corner_out=0; change idx 24 to 3999 -> corner_out=1.
4. thr=200: centre 199 dominant -> corner_out=0; centre 200 -> corner_out=1; iscorner=0 or valid_in=0 -> corner_out=0.
5. ce gating: insert ce=0 for 3 cycles between the two pipeline edges -> outputs hold and the result appears only after the second ce edge; stream 4 consecutive corner beats -> 4 consecutive valid_out cycles.
6. Counter with CNT_W=3: 9 corners after sof -> count 1..7, then holds at 7. sof beat that is itself a corner -> count=1. Assert rst low mid-stream -> all outputs 0 immediately, asynchronously, not waiting for clk.
